fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/fifo_uart_tx.sv | 135 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and frame constants.
// The PARITY state and parity helper exist only with FIFO_UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } uart_state_e;

`ifdef FIFO_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud divider: free-running 0..CLKS_PER_BIT-1 counter, cleared by the FSM on
// every state change so each bit period starts aligned with its state.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a registered-read sync FIFO and sends
// 8N1 frames (8E1 when FIFO_UART_TX_PARITY_EN is defined), LSB first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 bit_tick;
    logic                 cnt_clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .bit_tick (bit_tick)
    );

    assign cnt_clear = (state_d != state_q);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        fifo_rd   = 1'b0;
        tx_done   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Read data is valid this cycle, one after the pop strobe.
                shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = even_parity(fifo_data);
`endif
                state_d = START;
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            fifo_rd = 1'b0;
            tx_done = 1'b0;
        end
    end

    // Line level follows the next state so tx comes straight from a flop.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = !reset && ((state_q != IDLE) || fifo_rd);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx at CLKS_PER_BIT=4: stimulus queues bytes and
// their hand-computed frames, a negedge monitor decodes tx and compares.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected frame in time order from bit 0: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frm(input logic [7:0] d, input logic p);
`ifdef FIFO_UART_TX_PARITY_EN
        frm = {1'b1, p, d, 1'b0};
`else
        frm = {1'b0, 1'b1, d, 1'b0};
        if (p === 1'bx) frm = '0;
`endif
    endfunction

    // Upstream FIFO model with registered read data.
    logic [7:0] fmem [16];
    int         n_push = 0;
    int         n_pop  = 0;
    assign fifo_empty = (n_push == n_pop);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= fmem[n_pop % 16];
            n_pop     <= n_pop + 1;
        end
    end

    logic [10:0] exp_q [$];

    task automatic send(input logic [7:0] d, input logic [10:0] f, input bit expect_frame);
        fmem[n_push % 16] = d;
        if (expect_frame) exp_q.push_back(f);
        n_push = n_push + 1;
    endtask

    // Monitor: decodes frames off tx and checks strobes against the scoreboard.
    int          cyc = 0;
    int          done_cyc = 0;
    int          gap_last = -1;
    int          fcyc = 0;
    bit          active = 0;
    logic        cur_bit;
    logic        rd_prev = 1'b0;
    logic [10:0] got_frm;

    always @(negedge clk) begin
        cyc++;
        if (fifo_rd) begin
            chk("rd_while_empty", 32'(fifo_empty), 0);
            chk("busy_on_rd", 32'(busy), 1);
            chk("rd_single_cycle", 32'(rd_prev), 0);
        end
        rd_prev = fifo_rd;
        if (reset) begin
            active = 0;
        end else begin
            if (!active && tx == 1'b0) begin
                active   = 1;
                fcyc     = 0;
                got_frm  = '0;
                gap_last = cyc - done_cyc - 1;
            end
            if (active) begin
                fcyc++;
                if ((fcyc - 1) % CPB == 0) cur_bit = tx;
                else if (tx !== cur_bit) chk("bit_stable", 32'(tx), 32'(cur_bit));
                if ((fcyc - 1) % CPB == CPB / 2) got_frm[(fcyc - 1) / CPB] = tx;
                if (!busy) chk("busy_in_frame", 32'(busy), 1);
                if (fcyc == FB * CPB) begin
                    chk("tx_done_last_cycle", 32'(tx_done), 1);
                    done_cyc = cyc;
                    active   = 0;
                    chk("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("frame_bits", 32'(got_frm), 32'(exp_q.pop_front()));
                end else if (tx_done) begin
                    chk("tx_done_early", fcyc, FB * CPB);
                end
            end else if (tx_done) begin
                chk("tx_done_outside_frame", 32'(tx_done), 0);
            end
        end
    end

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tx_done && k < budget);
        chk("tx_done_seen", 32'(tx_done), 1);
    endtask

    task automatic wait_start(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx !== 1'b0 && k < budget);
        chk("start_seen", 32'(tx), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pop0;
        int bad_rd;
        int bad_tx;
        int bad_busy;

        // Reset with a byte already waiting: nothing may be popped yet.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(8'hA5, frm(8'hA5, 1'b0), 1);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fifo_rd", 32'(fifo_rd), 0);
        chk("rst_tx_done", 32'(tx_done), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single 0xA5 frame.
        wait_done(200);
        @(negedge clk);
        chk("a5_busy_after", 32'(busy), 0);
        chk("a5_one_rd", n_pop, 1);

        // Empty FIFO for 100 cycles.
        bad_rd = 0; bad_tx = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd) bad_rd++;
            if (tx !== 1'b1) bad_tx++;
            if (busy) bad_busy++;
        end
        chk("idle_fifo_rd", bad_rd, 0);
        chk("idle_tx", bad_tx, 0);
        chk("idle_busy", bad_busy, 0);

        // Back-to-back 0x01, 0x80.
        @(posedge clk);
        #1;
        pop0 = n_pop;
        send(8'h01, frm(8'h01, 1'b1), 1);
        send(8'h80, frm(8'h80, 1'b1), 1);
        wait_done(200);
        wait_done(200);
        chk("b2b_rd_count", n_pop - pop0, 2);
        chk("b2b_gap", gap_last, 2);

        // Byte arrives in the tx_done cycle: pop on the following cycle only.
        @(posedge clk);
        #1;
        send(8'hC3, frm(8'hC3, 1'b0), 1);
        wait_done(200);
        send(8'h3C, frm(8'h3C, 1'b0), 1);
        #1;
        chk("late_rd_not_early", 32'(fifo_rd), 0);
        @(negedge clk);
        chk("late_rd_next_cycle", 32'(fifo_rd), 1);
        wait_done(200);
        chk("late_gap", gap_last, 2);

`ifdef FIFO_UART_TX_PARITY_EN
        @(posedge clk);
        #1;
        send(8'h07, frm(8'h07, 1'b1), 1);
        wait_done(200);
`endif

        // Reset on cycle 18 of a 0xFF frame aborts it for good.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        pop0 = n_pop;
        send(8'hFF, '0, 0);
        wait_start(200);
        repeat (17) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(tx), 1);
        chk("abort_busy", 32'(busy), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_refetch", n_pop - pop0, 1);
        chk("abort_tx_idle", 32'(tx), 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_pops", n_pop, n_push);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
